// File: rtl/rover_i2c_target.sv
// I2C target (slave) with an Avalon-MM register port, receive FIFO and single-byte transmit register.
// Optional build macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module rover_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         RX_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        irq
);
    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_DEPTH);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic       r_scl_prev, r_sda_prev;
    logic       w_scl, w_sda;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1   <= scl_in;
            r_scl_s2   <= r_scl_s1;
            r_sda_s1   <= sda_in;
            r_sda_s2   <= r_sda_s1;
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist, r_sda_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_s2};
        end
    end

    assign w_scl = (r_scl_hist[0] & r_scl_hist[1]) | (r_scl_hist[0] & r_scl_hist[2]) |
                   (r_scl_hist[1] & r_scl_hist[2]);
    assign w_sda = (r_sda_hist[0] & r_sda_hist[1]) | (r_sda_hist[0] & r_sda_hist[2]) |
                   (r_sda_hist[1] & r_sda_hist[2]);
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // Register file and FIFO state
    logic [7:0]       r_mem [RX_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_txdata;
    logic             r_overflow, r_tx_empty, r_enable, r_irq_en;

    // Protocol engine state
    state_t     r_state, w_next_state;
    logic [2:0] r_bit_cnt, w_next_bit_cnt;
    logic [7:0] r_shift, w_next_shift;
    logic       r_sda_oe, w_next_sda_oe;
    logic       r_ack_drv, w_next_ack_drv;
    logic       r_ack, w_next_ack;
    logic       r_rw, w_next_rw;
    logic       w_push, w_ovf_set, w_tx_load;
    logic [7:0] w_rx_byte;

    logic w_rx_nonempty, w_rx_full, w_busy, w_wr, w_pop;
    logic w_unused_wdata;

    assign w_rx_nonempty  = (r_count != '0);
    assign w_rx_full      = (r_count == FULL_CNT);
    assign w_busy         = (r_state != IDLE);
    assign w_wr           = chipselect & ~write_n;
    assign w_pop          = chipselect & ~read_n & (address == 2'd0) & w_rx_nonempty;
    assign w_rx_byte      = {r_shift[6:0], w_sda};
    assign w_unused_wdata = ^writedata[31:8];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_next_bit_cnt = r_bit_cnt;
        w_next_shift   = r_shift;
        w_next_sda_oe  = r_sda_oe;
        w_next_ack_drv = r_ack_drv;
        w_next_ack     = r_ack;
        w_next_rw      = r_rw;
        w_push         = 1'b0;
        w_ovf_set      = 1'b0;
        w_tx_load      = 1'b0;
        if (w_stop) begin
            w_next_state  = IDLE;
            w_next_sda_oe = 1'b0;
        end else if (w_start) begin
            w_next_state   = ADDR;
            w_next_bit_cnt = 3'd0;
            w_next_sda_oe  = 1'b0;
            w_next_ack_drv = 1'b0;
        end else begin
            case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_next_shift   = w_rx_byte;
                    w_next_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next_rw      = w_sda;
                        w_next_ack_drv = 1'b0;
                        w_next_state   = (r_shift[6:0] == SLAVE_ADDR && r_enable) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                // Each ACK state sees two SCL falls: the first drives the ACK bit, the second ends it.
                ADDR_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_next_sda_oe  = 1'b1;
                        w_next_ack_drv = 1'b1;
                    end else begin
                        w_next_ack_drv = 1'b0;
                        w_next_bit_cnt = 3'd0;
                        if (r_rw) begin
                            w_next_state  = TX;
                            w_next_shift  = r_txdata;
                            w_next_sda_oe = ~r_txdata[7];
                            w_tx_load     = 1'b1;
                        end else begin
                            w_next_state  = RX;
                            w_next_sda_oe = 1'b0;
                        end
                    end
                end
                RX: if (w_scl_rise) begin
                    w_next_shift   = w_rx_byte;
                    w_next_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_push         = ~w_rx_full;
                        w_ovf_set      = w_rx_full;
                        w_next_ack     = ~w_rx_full;
                        w_next_ack_drv = 1'b0;
                        w_next_state   = RX_ACK;
                    end
                end
                RX_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_next_sda_oe  = r_ack;
                        w_next_ack_drv = 1'b1;
                    end else begin
                        w_next_sda_oe  = 1'b0;
                        w_next_ack_drv = 1'b0;
                        w_next_bit_cnt = 3'd0;
                        w_next_state   = RX;
                    end
                end
                TX: if (w_scl_rise) begin
                    w_next_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next_ack_drv = 1'b0;
                        w_next_state   = TX_ACK;
                    end
                end else if (w_scl_fall) begin
                    w_next_shift  = {r_shift[6:0], 1'b0};
                    w_next_sda_oe = ~r_shift[6];
                end
                // r_ack_drv here records that the master ACKed the byte just sent.
                TX_ACK: if (w_scl_rise) begin
                    if (w_sda) w_next_state = WAIT_STOP;
                    else       w_next_ack_drv = 1'b1;
                end else if (w_scl_fall) begin
                    if (r_ack_drv) begin
                        w_next_state   = TX;
                        w_next_shift   = r_txdata;
                        w_next_sda_oe  = ~r_txdata[7];
                        w_next_bit_cnt = 3'd0;
                        w_next_ack_drv = 1'b0;
                        w_tx_load      = 1'b1;
                    end else begin
                        w_next_sda_oe = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_sda_oe  <= 1'b0;
            r_ack_drv <= 1'b0;
            r_ack     <= 1'b0;
            r_rw      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_next_bit_cnt;
            r_shift   <= w_next_shift;
            r_sda_oe  <= w_next_sda_oe;
            r_ack_drv <= w_next_ack_drv;
            r_ack     <= w_next_ack;
            r_rw      <= w_next_rw;
        end
    end

    // NOTE: FIFO storage has no reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_rx_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_txdata   <= 8'hFF;
            r_overflow <= 1'b0;
            r_tx_empty <= 1'b1;
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);

            if (w_wr && address == 2'd1) r_txdata <= writedata[7:0];
            if (w_tx_load)                                   r_tx_empty <= 1'b1;
            else if (w_wr && address == 2'd1)                r_tx_empty <= 1'b0;
            if (w_ovf_set)                                   r_overflow <= 1'b1;
            else if (w_wr && address == 2'd2 && writedata[3]) r_overflow <= 1'b0;
            if (w_wr && address == 2'd3) begin
                r_enable <= writedata[0];
                r_irq_en <= writedata[1];
            end
        end
    end

    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0: readdata = {24'h0, w_rx_nonempty ? r_mem[r_rptr] : 8'h00};
            2'd2: readdata = {27'h0, r_tx_empty, r_overflow, w_busy, w_rx_full, w_rx_nonempty};
            2'd3: readdata = {30'h0, r_irq_en, r_enable};
            default: readdata = 32'h0;
        endcase
    end

    assign sda_oe = r_sda_oe;
    assign irq    = r_irq_en & (w_rx_nonempty | r_overflow |
                    (r_tx_empty & (r_state == TX || r_state == TX_ACK)));

endmodule
